// File: rtl/cmd_seq.sv
// Script-driven command sequencer for the CommMaster UART link: replays stored
// cmd/data entries with a response timeout, bounded retries and pass/fail status.
module cmd_seq #(
  parameter int         DEPTH   = 16,
  parameter int         TMO_CYC = 3000000,
  parameter int         SW      = 28,
  parameter int         RETRIES = 2,
  parameter logic [7:0] POSACK  = 8'hA5,
  localparam int        AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_cmd,
  input  logic [15:0]   wr_data,
  input  logic [SW-1:0] wr_settle,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic [7:0]    cmd,
  output logic [15:0]   data,
  output logic          send_cmd,
  output logic          clr_resp_rdy,
  input  logic          frm_snt,
  input  logic          resp_rdy,
  input  logic [7:0]    resp,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [AW-1:0] fail_idx,
  output logic [1:0]    fail_code,
  output logic [7:0]    last_resp
);

  // One down-counter serves both the response timeout and the settle delay.
  localparam int CW = (SW > $clog2(TMO_CYC + 1)) ? SW : $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] L_TMO_LOAD = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] L_CNT_ONE  = CW'(1);
  localparam logic [2:0]    L_RETRIES  = 3'(RETRIES);
  localparam logic [AW:0]   L_DEPTH    = DEPTH[AW:0];
  localparam logic [AW:0]   L_LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] L_IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SEND   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  logic [2:0]    r_state;
  logic [7:0]    r_mem_cmd    [DEPTH];
  logic [15:0]   r_mem_data   [DEPTH];
  logic [SW-1:0] r_mem_settle [DEPTH];
  logic [AW:0]   r_len;
  logic [AW-1:0] r_idx;
  logic [2:0]    r_attempts;
  logic [CW-1:0] r_cnt;
  logic          r_resp_rdy_q;
  logic [7:0]    r_cmd;
  logic [15:0]   r_data;
  logic          r_pass;
  logic          r_fail;
  logic [AW-1:0] r_fail_idx;
  logic [1:0]    r_fail_code;
  logic [7:0]    r_last_resp;

  logic          w_rise;
  logic          w_last_entry;
  logic [AW:0]   w_len_clamped;
  logic          w_unused_frm_snt;

  assign w_rise        = resp_rdy & ~r_resp_rdy_q;
  assign w_last_entry  = ({1'b0, r_idx} + L_LEN_ONE) == r_len;
  assign w_len_clamped = (len > L_DEPTH) ? L_DEPTH : len;
  // Frame-sent carries no decision in this block; no status port exposes it.
  assign w_unused_frm_snt = frm_snt;

  // NOTE: the script is a flop array, so it can and must be cleared by reset;
  // a macro RAM could not be, and the loop below would not map onto one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_cmd[i]    <= '0;
        r_mem_data[i]   <= '0;
        r_mem_settle[i] <= '0;
      end
    end else if (wr_en && (r_state == S_IDLE)) begin
      r_mem_cmd[wr_addr]    <= wr_cmd;
      r_mem_data[wr_addr]   <= wr_data;
      r_mem_settle[wr_addr] <= wr_settle;
    end
  end

  // NOTE: all state updates use <= so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_idx        <= '0;
      r_attempts   <= '0;
      r_cnt        <= '0;
      r_resp_rdy_q <= 1'b0;
      r_cmd        <= '0;
      r_data       <= '0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_code  <= '0;
      r_last_resp  <= '0;
    end else begin
      r_resp_rdy_q <= resp_rdy;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len       <= w_len_clamped;
            r_idx       <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_idx  <= '0;
            r_fail_code <= '0;
            if (w_len_clamped == '0) begin
              r_pass  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          r_cmd      <= r_mem_cmd[r_idx];
          r_data     <= r_mem_data[r_idx];
          r_attempts <= '0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          r_cnt   <= L_TMO_LOAD;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A fresh edge on the last counted cycle still beats the timeout.
          if (w_rise) begin
            r_last_resp <= resp;
            r_state     <= S_CHECK;
          end else if (r_cnt == '0) begin
            if (r_attempts < L_RETRIES) begin
              r_attempts <= r_attempts + 3'd1;
              r_state    <= S_SEND;
            end else begin
              r_fail      <= 1'b1;
              r_fail_idx  <= r_idx;
              r_fail_code <= 2'd1;
              r_state     <= S_FINISH;
            end
          end else begin
            r_cnt <= r_cnt - L_CNT_ONE;
          end
        end
        S_CHECK: begin
          if (r_last_resp == POSACK) begin
            r_cnt   <= CW'(r_mem_settle[r_idx]);
            r_state <= S_SETTLE;
          end else if (r_attempts < L_RETRIES) begin
            r_attempts <= r_attempts + 3'd1;
            r_state    <= S_SEND;
          end else begin
            r_fail      <= 1'b1;
            r_fail_idx  <= r_idx;
            r_fail_code <= 2'd2;
            r_state     <= S_FINISH;
          end
        end
        S_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - L_CNT_ONE;
          end else if (w_last_entry) begin
            r_pass  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_idx   <= r_idx + L_IDX_ONE;
            r_state <= S_FETCH;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd          = r_cmd;
  assign data         = r_data;
  assign send_cmd     = (r_state == S_SEND);
  assign clr_resp_rdy = (r_state == S_CHECK);
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_FINISH);
  assign pass         = r_pass;
  assign fail         = r_fail;
  assign fail_idx     = r_fail_idx;
  assign fail_code    = r_fail_code;
  assign last_resp    = r_last_resp;

endmodule

// File: tb/tb_cmd_seq.sv
// Bench for cmd_seq: a cycle-timeline model of each run plus a scripted
// CommMaster responder; outputs are compared on every falling edge.
module tb_cmd_seq;

  localparam int         DEPTH = 4;
  localparam int         AW    = 2;
  localparam int         TMO   = 50;
  localparam int         SW    = 12;
  localparam int         RET   = 2;
  localparam logic [7:0] ACK   = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_cmd = '0;
  logic [15:0]   wr_data = '0;
  logic [SW-1:0] wr_settle = '0;
  logic [AW:0]   len = '0;
  logic          start = 1'b0;
  logic          frm_snt = 1'b0;
  logic          resp_rdy = 1'b0;
  logic [7:0]    resp = '0;
  logic [7:0]    cmd;
  logic [15:0]   data;
  logic          send_cmd, clr_resp_rdy, busy, done, pass, fail;
  logic [AW-1:0] fail_idx;
  logic [1:0]    fail_code;
  logic [7:0]    last_resp;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cmd_seq #(.DEPTH(DEPTH), .TMO_CYC(TMO), .SW(SW), .RETRIES(RET), .POSACK(ACK)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_cmd(wr_cmd),
    .wr_data(wr_data), .wr_settle(wr_settle), .len(len), .start(start),
    .cmd(cmd), .data(data), .send_cmd(send_cmd), .clr_resp_rdy(clr_resp_rdy),
    .frm_snt(frm_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .fail_idx(fail_idx), .fail_code(fail_code),
    .last_resp(last_resp)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scripted CommMaster behaviour, one entry per send_cmd pulse of a run.
  typedef struct {
    bit         valid;
    int         d;
    logic [7:0] b;
    bit         keep;
  } rsp_t;
  rsp_t rsp_q[$];
  int   n_sent = 0;

  task automatic add_rsp(input bit v, input int d, input logic [7:0] b, input bit k);
    rsp_t r;
    r.valid = v; r.d = d; r.b = b; r.keep = k;
    rsp_q.push_back(r);
  endtask

  // Responder: drop resp_rdy one cycle before the answer so every answer is a
  // fresh rising edge; knock it down on clr_resp_rdy unless told to hold it.
  initial begin : responder
    bit         pend = 1'b0;
    bit         hold = 1'b0;
    int         due = 0;
    logic [7:0] pb = '0;
    bit         pk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && send_cmd) begin
        if (n_sent < rsp_q.size() && rsp_q[n_sent].valid) begin
          pend = 1'b1;
          due  = cyc + rsp_q[n_sent].d;
          pb   = rsp_q[n_sent].b;
          pk   = rsp_q[n_sent].keep;
        end
        n_sent++;
      end
      if (pend && cyc == due - 1) resp_rdy = 1'b0;
      if (pend && cyc == due) begin
        resp_rdy = 1'b1;
        resp     = pb;
        hold     = pk;
        pend     = 1'b0;
      end
      if (clr_resp_rdy && !hold) resp_rdy = 1'b0;
    end
  end

  // Model: script mirror and the expected timeline of one run.
  logic [7:0]  m_cmd    [DEPTH];
  logic [15:0] m_data   [DEPTH];
  int          m_settle [DEPTH];
  logic [7:0]  m_last = '0;
  bit          exp_send_at [int];
  logic [23:0] exp_cd      [int];
  bit          exp_clr_at  [int];
  int          exp_lo, exp_fin, exp_fidx, exp_fcode;
  bit          exp_pass, exp_fail;

  // Start is sampled at the end of cycle s; the run's first cycle is s+1.
  function automatic void build_model(input int s, input int n);
    int ne, t, k, snd, nxt, cause;
    exp_send_at.delete(); exp_cd.delete(); exp_clr_at.delete();
    ne = (n > DEPTH) ? DEPTH : n;
    t = s + 1; k = 0;
    exp_lo = s + 1; exp_pass = 0; exp_fail = 0; exp_fidx = 0; exp_fcode = 0;
    if (ne == 0) begin
      exp_fin = s + 1; exp_pass = 1;
      return;
    end
    for (int e = 0; e < ne; e++) begin
      snd = t + 1;
      for (int a = 0; a <= RET; a++) begin
        exp_send_at[snd] = 1'b1;
        exp_cd[snd] = {m_cmd[e], m_data[e]};
        if (k < rsp_q.size() && rsp_q[k].valid) begin
          int e_cyc;
          e_cyc = snd + rsp_q[k].d;
          exp_clr_at[e_cyc + 1] = 1'b1;
          m_last = rsp_q[k].b;
          k++;
          if (rsp_q[k-1].b == ACK) begin
            t = e_cyc + 3 + m_settle[e];
            break;
          end
          cause = 2; nxt = e_cyc + 2;
        end else begin
          k++;
          cause = 1; nxt = snd + TMO + 1;
        end
        if (a == RET) begin
          exp_fail = 1; exp_fidx = e; exp_fcode = cause; exp_fin = nxt;
          return;
        end
        snd = nxt;
      end
    end
    exp_fin = t; exp_pass = 1;
  endfunction

  // Compare process.
  bit         mon_en = 1'b0;
  int         obs_send[$];
  logic [7:0] obs_cmd[$];
  int         obs_done = -1;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        bit es, ec;
        es = exp_send_at.exists(cyc) != 0;
        ec = exp_clr_at.exists(cyc) != 0;
        check("send_cmd", 32'(send_cmd), 32'(es));
        if (es) check("cmd_data", 32'({cmd, data}), 32'(exp_cd[cyc]));
        check("clr_resp_rdy", 32'(clr_resp_rdy), 32'(ec));
        check("busy", 32'(busy), 32'(cyc >= exp_lo && cyc <= exp_fin));
        check("done", 32'(done), 32'(cyc == exp_fin));
        if (send_cmd) begin
          obs_send.push_back(cyc);
          obs_cmd.push_back(cmd);
        end
        if (done) obs_done = cyc;
      end
    end
  end

  function automatic int gap(input int i);
    if (obs_send.size() > i) return obs_send[i] - obs_send[i-1];
    return -1;
  endfunction

  function automatic int ocmd(input int i);
    if (obs_cmd.size() > i) return int'(obs_cmd[i]);
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [7:0] c, input logic [15:0] d,
                    input int st, input bit mirror);
    wr_en = 1'b1; wr_addr = AW'(a); wr_cmd = c; wr_data = d; wr_settle = SW'(st);
    @(negedge clk);
    wr_en = 1'b0;
    if (mirror) begin
      m_cmd[a] = c; m_data[a] = d; m_settle[a] = st;
    end
  endtask

  int run_s;

  task automatic run_start(input int n);
    run_s = cyc;
    n_sent = 0;
    obs_send.delete(); obs_cmd.delete(); obs_done = -1;
    build_model(run_s, n);
    len = (AW+1)'(n); start = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_wait();
    for (int i = 0; i < 20000; i++) begin
      if (cyc >= exp_fin + 2) break;
      @(negedge clk);
    end
    mon_en = 1'b0;
    check("pass", 32'(pass), 32'(exp_pass));
    check("fail", 32'(fail), 32'(exp_fail));
    check("fail_idx", 32'(fail_idx), 32'(exp_fidx));
    check("fail_code", 32'(fail_code), 32'(exp_fcode));
    check("last_resp", 32'(last_resp), 32'(m_last));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_send_cmd"}, 32'(send_cmd), 0);
    check({tag, "_clr"}, 32'(clr_resp_rdy), 0);
    check({tag, "_cmd"}, 32'(cmd), 0);
    check({tag, "_data"}, 32'(data), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_fail"}, 32'(fail), 0);
    check({tag, "_fail_idx"}, 32'(fail_idx), 0);
    check({tag, "_fail_code"}, 32'(fail_code), 0);
    check({tag, "_last_resp"}, 32'(last_resp), 0);
  endtask

  initial begin : main
    for (int i = 0; i < DEPTH; i++) begin
      m_cmd[i] = '0; m_data[i] = '0; m_settle[i] = 0;
    end
    tick(2);
    check_zero("rst");
    rst_n = 1'b1;
    tick(1);

    // Three-entry script, every answer positive.
    wr(0, 8'h06, 16'h0000, 0, 1);
    wr(1, 8'h05, 16'h01FF, 100, 1);
    wr(2, 8'h03, 16'h0050, 1000, 1);
    rsp_q.delete();
    repeat (3) add_rsp(1, 3, ACK, 0);
    run_start(3); run_wait();
    check("s1_sends", 32'(obs_send.size()), 3);
    check("s1_start_lat", 32'(obs_send.size() > 0 ? obs_send[0] - run_s : -1), 2);
    check("s1_gap01", 32'(gap(1)), 7);
    check("s1_gap12", 32'(gap(2)), 107);
    check("s1_cmd1", 32'(ocmd(1)), 32'h05);
    check("s1_pass", 32'(pass), 1);

    // Entry 1 answered with NAK twice, then accepted.
    rsp_q.delete();
    add_rsp(1, 3, ACK, 0); add_rsp(1, 3, 8'hEE, 0); add_rsp(1, 3, 8'hEE, 0);
    add_rsp(1, 3, ACK, 0); add_rsp(1, 3, ACK, 0);
    run_start(3); run_wait();
    check("s2_sends", 32'(obs_send.size()), 5);
    check("s2_retry_cmd", 32'(ocmd(3)), 32'h05);
    check("s2_nak_gap", 32'(gap(2)), 5);
    check("s2_pass", 32'(pass), 1);

    // No answer at all: every attempt on entry 0 times out.
    rsp_q.delete();
    run_start(3); run_wait();
    check("s3_sends", 32'(obs_send.size()), 3);
    check("s3_tmo_gap", 32'(gap(1)), 51);
    check("s3_fail_code", 32'(fail_code), 1);

    // NAKs exhaust the retries on entry 1.
    rsp_q.delete();
    add_rsp(1, 2, ACK, 0);
    repeat (3) add_rsp(1, 2, 8'hEE, 0);
    run_start(3); run_wait();
    check("s4_fail_idx", 32'(fail_idx), 1);
    check("s4_last_resp", 32'(last_resp), 32'hEE);

    // Zero-length run.
    rsp_q.delete();
    run_start(0); run_wait();
    check("s5_done_lat", 32'(obs_done - run_s), 1);
    check("s5_sends", 32'(obs_send.size()), 0);

    // Writes and start while busy are ignored.
    rsp_q.delete();
    add_rsp(1, 3, ACK, 0);
    run_start(1);
    wr_en = 1'b1; wr_addr = '0; wr_cmd = 8'h77; wr_data = 16'hBEEF; start = 1'b1; len = 3'd3;
    tick(2);
    wr_en = 1'b0; start = 1'b0;
    run_wait();
    check("s6_sends", 32'(obs_send.size()), 1);
    rsp_q.delete();
    add_rsp(1, 3, ACK, 0);
    run_start(1); run_wait();
    check("s6_script_kept", 32'(ocmd(0)), 32'h06);

    // Length above DEPTH clamps to DEPTH.
    wr(3, 8'h42, 16'h1234, 2, 1);
    rsp_q.delete();
    repeat (4) add_rsp(1, 2, ACK, 0);
    run_start(7); run_wait();
    check("s7_sends", 32'(obs_send.size()), 4);

    // resp_rdy left high by the previous run must not be accepted; an edge on
    // the final timeout cycle still counts.
    rsp_q.delete();
    add_rsp(1, 3, ACK, 1);
    run_start(1); run_wait();
    rsp_q.delete();
    add_rsp(0, 0, 8'h00, 0);
    add_rsp(1, TMO, ACK, 0);
    run_start(1); run_wait();
    check("s8_stale_gap", 32'(gap(1)), 51);
    check("s8_pass", 32'(pass), 1);

    // Asynchronous reset while waiting for a response.
    rsp_q.delete();
    run_start(1);
    tick(4);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    for (int i = 0; i < DEPTH; i++) begin
      m_cmd[i] = '0; m_data[i] = '0; m_settle[i] = 0;
    end
    m_last = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    rsp_q.delete();
    add_rsp(1, 3, ACK, 0);
    run_start(1); run_wait();
    check("s9_cleared_cmd", 32'(ocmd(0)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
